// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core instruction sequencer: instruction layout,
// idle word, FSM state codes and default tile geometry.
package core_ctrl_pkg;

    localparam int INST_W       = 34;
    localparam int INST_LOAD    = 0;
    localparam int INST_EXECUTE = 1;
    localparam int INST_L0_WR   = 2;
    localparam int INST_L0_RD   = 3;
    localparam int INST_IF_RD   = 4;
    localparam int INST_IF_WR   = 5;
    localparam int INST_OF_RD   = 6;
    localparam int INST_AX_LSB  = 7;
    localparam int INST_WEN_X   = 18;
    localparam int INST_CEN_X   = 19;
    localparam int INST_AP_LSB  = 20;
    localparam int INST_WEN_P   = 31;
    localparam int INST_CEN_P   = 32;
    localparam int INST_ACC     = 33;

    typedef struct packed {
        logic        acc;
        logic        cen_p;
        logic        wen_p;
        logic [10:0] a_p;
        logic        cen_x;
        logic        wen_x;
        logic [10:0] a_x;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    // Both SRAMs deselected, every strobe low.
    localparam inst_t IDLE_INST = 34'h1_800C_0000;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_W_L0   = 4'd1;
    localparam logic [3:0] S_W_LOAD = 4'd2;
    localparam logic [3:0] S_GAP1   = 4'd3;
    localparam logic [3:0] S_X_L0   = 4'd4;
    localparam logic [3:0] S_EXEC   = 4'd5;
    localparam logic [3:0] S_GAP2   = 4'd6;
    localparam logic [3:0] S_DRAIN  = 4'd7;
    localparam logic [3:0] S_ACC    = 4'd8;
    localparam logic [3:0] S_FIN    = 4'd9;

    localparam int COL_DEF      = 8;
    localparam int LEN_KIJ_DEF  = 9;
    localparam int LEN_NIJ_DEF  = 36;
    localparam int IW_DEF       = 6;
    localparam int KA_DEF       = 3;
    localparam int WGT_BASE_DEF = 11'h400;
    localparam int GAP_CYC_DEF  = 10;

endpackage

// File: rtl/core_ctrl_acc_addr.sv
// Psum accumulation address generator: walks output pixels o and kernel
// positions k, producing pmem read addresses and the delayed acc strobe.
module core_ctrl_acc_addr
    import core_ctrl_pkg::*;
#(
    parameter int LEN_KIJ = LEN_KIJ_DEF,
    parameter int LEN_NIJ = LEN_NIJ_DEF,
    parameter int IW      = IW_DEF,
    parameter int KA      = KA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        rd,
    output logic        acc,
    output logic [10:0] a_p,
    output logic        last
);

    localparam int OW  = IW - KA + 1;
    // 2 SFP-clear cycles, LEN_KIJ reads, trailing acc, one acc=0 cycle
    localparam int GRP = LEN_KIJ + 4;

    localparam logic [5:0] P_RD0  = 6'd2;
    localparam logic [5:0] P_RD1  = 6'(2 + LEN_KIJ);
    localparam logic [5:0] P_AC0  = 6'd3;
    localparam logic [5:0] P_AC1  = 6'(3 + LEN_KIJ);
    localparam logic [5:0] P_END  = 6'(GRP - 1);
    localparam logic [3:0] K_LAST = 4'(KA - 1);
    localparam logic [3:0] O_LAST = 4'(OW - 1);
    localparam logic [10:0] NIJ_A = 11'(LEN_NIJ);
    localparam logic [10:0] IW_A  = 11'(IW);

    logic [5:0] p;
    logic [3:0] orow;
    logic [3:0] ocol;
    logic [3:0] krow;
    logic [3:0] kcol;
    logic [3:0] k;

    assign rd   = (p >= P_RD0) && (p < P_RD1);
    assign acc  = (p >= P_AC0) && (p < P_AC1);
    assign last = (p == P_END) && (orow == O_LAST) && (ocol == O_LAST);

    assign a_p = 11'(k) * NIJ_A
               + (11'(orow) + 11'(krow)) * IW_A
               + 11'(ocol) + 11'(kcol);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p    <= '0;
            orow <= '0;
            ocol <= '0;
            krow <= '0;
            kcol <= '0;
            k    <= '0;
        end else if (!en) begin
            p    <= '0;
            orow <= '0;
            ocol <= '0;
            krow <= '0;
            kcol <= '0;
            k    <= '0;
        end else if (p == P_END) begin
            p    <= '0;
            krow <= '0;
            kcol <= '0;
            k    <= '0;
            if (ocol == O_LAST) begin
                ocol <= '0;
                orow <= orow + 4'd1;
            end else begin
                ocol <= ocol + 4'd1;
            end
        end else begin
            p <= p + 6'd1;
            if (rd) begin
                k <= k + 4'd1;
                if (kcol == K_LAST) begin
                    kcol <= '0;
                    krow <= krow + 4'd1;
                end else begin
                    kcol <= kcol + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/core_ctrl_seq.sv
// Conv-pass sequencer driving the registered 34-bit core instruction bus.
// Optional psum accumulation phase enabled by defining ACC_PHASE_EN.
module core_ctrl_seq
    import core_ctrl_pkg::*;
#(
    parameter int COL      = COL_DEF,
    parameter int LEN_KIJ  = LEN_KIJ_DEF,
    parameter int LEN_NIJ  = LEN_NIJ_DEF,
    parameter int WGT_BASE = WGT_BASE_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_cnt
);

    localparam logic [7:0]  COL_T    = 8'(COL);
    localparam logic [7:0]  NIJ_T    = 8'(LEN_NIJ);
    localparam logic [7:0]  NIJ_LAST = 8'(LEN_NIJ - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [3:0]  KIJ_LAST = 4'(LEN_KIJ - 1);
    localparam logic [10:0] COL_A    = 11'(COL);
    localparam logic [10:0] NIJ_A    = 11'(LEN_NIJ);
    localparam logic [10:0] WGT_A    = 11'(WGT_BASE);

    logic [3:0] state;
    logic [3:0] state_d;
    logic [7:0] t;
    logic [7:0] t_d;
    logic [3:0] kij;
    logic [3:0] kij_d;
    inst_t      inst_q;
    inst_t      inst_d;

`ifdef ACC_PHASE_EN
    logic        acc_rd;
    logic        acc_bit;
    logic [10:0] acc_ap;
    logic        acc_last;

    core_ctrl_acc_addr #(
        .LEN_KIJ(LEN_KIJ),
        .LEN_NIJ(LEN_NIJ),
        .IW     (IW_DEF),
        .KA     (KA_DEF)
    ) u_acc_addr (
        .clk  (clk),
        .reset(reset),
        .en   (state == S_ACC),
        .rd   (acc_rd),
        .acc  (acc_bit),
        .a_p  (acc_ap),
        .last (acc_last)
    );
`endif

    assign inst    = inst_q;
    assign busy    = (state != S_IDLE) && (state != S_FIN);
    assign done    = (state == S_FIN);
    assign kij_cnt = kij;

    always_comb begin
        state_d = state;
        t_d     = t + 8'd1;
        kij_d   = kij;
        inst_d  = IDLE_INST;
        unique case (state)
            S_IDLE: begin
                t_d   = '0;
                kij_d = '0;
                if (start) begin
                    state_d = S_W_L0;
                end
            end
            S_W_L0: begin
                if (t < COL_T) begin
                    inst_d.cen_x = 1'b0;
                    inst_d.a_x   = WGT_A + 11'(kij) * COL_A + 11'(t);
                end
                inst_d.l0_wr = (t != 8'd0);
                if (t == COL_T) begin
                    state_d = S_W_LOAD;
                    t_d     = '0;
                end
            end
            S_W_LOAD: begin
                inst_d.l0_rd = (t < COL_T);
                inst_d.load  = (t != 8'd0);
                if (t == COL_T) begin
                    state_d = S_GAP1;
                    t_d     = '0;
                end
            end
            S_GAP1: begin
                if (t == GAP_LAST) begin
                    state_d = S_X_L0;
                    t_d     = '0;
                end
            end
            S_X_L0: begin
                if (t < NIJ_T) begin
                    inst_d.cen_x = 1'b0;
                    inst_d.a_x   = 11'(t);
                end
                inst_d.l0_wr = (t != 8'd0);
                if (t == NIJ_T) begin
                    state_d = S_EXEC;
                    t_d     = '0;
                end
            end
            S_EXEC: begin
                inst_d.l0_rd   = (t < NIJ_T);
                inst_d.execute = (t != 8'd0);
                if (t == NIJ_T) begin
                    state_d = S_GAP2;
                    t_d     = '0;
                end
            end
            S_GAP2: begin
                if (t == GAP_LAST) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end
            end
            S_DRAIN: begin
                t_d = t;
                // Without a full OFIFO row the write is skipped and t holds.
                if (ofifo_valid) begin
                    inst_d.ofifo_rd = 1'b1;
                    inst_d.cen_p    = 1'b0;
                    inst_d.wen_p    = 1'b0;
                    inst_d.a_p      = 11'(kij) * NIJ_A + 11'(t);
                    t_d             = t + 8'd1;
                    if (t == NIJ_LAST) begin
                        t_d = '0;
                        if (kij == KIJ_LAST) begin
`ifdef ACC_PHASE_EN
                            state_d = S_ACC;
`else
                            state_d = S_FIN;
`endif
                        end else begin
                            kij_d   = kij + 4'd1;
                            state_d = S_W_L0;
                        end
                    end
                end
            end
`ifdef ACC_PHASE_EN
            S_ACC: begin
                t_d          = '0;
                inst_d.cen_p = ~acc_rd;
                inst_d.a_p   = acc_rd ? acc_ap : 11'd0;
                inst_d.acc   = acc_bit;
                if (acc_last) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                t_d     = '0;
                kij_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                t_d     = '0;
                kij_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            t      <= '0;
            kij    <= '0;
            inst_q <= IDLE_INST;
        end else begin
            state  <= state_d;
            t      <= t_d;
            kij    <= kij_d;
            inst_q <= inst_d;
        end
    end

endmodule
